// File: rtl/vnu_pipe.sv
// Min-sum LDPC variable-node update: two-stage pipeline, 1 node/cycle, latency 2.
// Stage 1 registers the total, stage 2 forms saturated extrinsics, posterior and hard decision.
module vnu_pipe #(
  parameter int W  = 8,
  parameter int DV = 3,
  parameter int SW = W + 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vnu_en,
  output logic            in_ready,
  input  logic            first_iter,
  input  logic [W-1:0]    intrinsic_info,
  input  logic [DV*W-1:0] msg_from_check,
  output logic [DV*W-1:0] msg_to_check,
  output logic [W-1:0]    posterior,
  output logic            hard_bit,
  output logic            sat_flag,
  output logic            vnu_over,
  input  logic            out_ready
);

  // Symmetric clamp: the most negative code is never emitted.
  localparam logic signed [SW-1:0] SAT_HI = SW'((2 ** (W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_LO = -SAT_HI;

  function automatic logic signed [SW-1:0] sext(input logic [W-1:0] v);
    return {{(SW - W){v[W-1]}}, v};
  endfunction

  // Returns {saturated, value}.
  function automatic logic [W:0] sat_w(input logic signed [SW-1:0] v);
    if (v > SAT_HI)      return {1'b1, SAT_HI[W-1:0]};
    else if (v < SAT_LO) return {1'b1, SAT_LO[W-1:0]};
    else                 return {1'b0, v[W-1:0]};
  endfunction

  logic                   s1_valid;
  logic                   s1_first;
  logic [W-1:0]           s1_intr;
  logic [DV*W-1:0]        s1_msg;
  logic signed [SW-1:0]   s1_total;
  logic signed [SW-1:0]   in_total;
  logic                   s1_adv;
  logic                   s2_adv;

  assign s2_adv   = !vnu_over || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    in_total = sext(intrinsic_info);
    for (int i = 0; i < DV; i++) begin
      in_total = in_total + sext(msg_from_check[i*W +: W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_intr  <= '0;
      s1_msg   <= '0;
      s1_total <= '0;
    end else if (s1_adv) begin
      s1_valid <= vnu_en;
      if (vnu_en) begin
        s1_first <= first_iter;
        s1_intr  <= intrinsic_info;
        s1_msg   <= msg_from_check;
        s1_total <= in_total;
      end
    end
  end

  logic [DV*W-1:0] nx_msg;
  logic [W-1:0]    nx_post;
  logic            nx_hb;
  logic            nx_sat;
  logic [W:0]      r;

  always_comb begin
    nx_msg  = '0;
    nx_post = '0;
    nx_hb   = 1'b0;
    nx_sat  = 1'b0;
    r       = '0;
    if (s1_first) begin
      r = sat_w(sext(s1_intr));
      for (int i = 0; i < DV; i++) begin
        nx_msg[i*W +: W] = r[W-1:0];
      end
      nx_post = r[W-1:0];
      nx_hb   = s1_intr[W-1];
      nx_sat  = r[W];
    end else begin
      for (int i = 0; i < DV; i++) begin
        r = sat_w(s1_total - sext(s1_msg[i*W +: W]));
        nx_msg[i*W +: W] = r[W-1:0];
        nx_sat = nx_sat | r[W];
      end
      r       = sat_w(s1_total);
      nx_post = r[W-1:0];
      nx_sat  = nx_sat | r[W];
      // Hard decision follows the unsaturated total.
      nx_hb   = s1_total[SW-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vnu_over     <= 1'b0;
      msg_to_check <= '0;
      posterior    <= '0;
      hard_bit     <= 1'b0;
      sat_flag     <= 1'b0;
    end else if (s2_adv) begin
      vnu_over <= s1_valid;
      if (s1_valid) begin
        msg_to_check <= nx_msg;
        posterior    <= nx_post;
        hard_bit     <= nx_hb;
        sat_flag     <= nx_sat;
      end
    end
  end

endmodule

// File: tb/tb_vnu_pipe.sv
// Bench for vnu_pipe: directed vectors, backpressure, reset and randomized streams vs an integer model.
module tb_vnu_pipe;
  localparam int W  = 8;
  localparam int DV = 3;
  localparam int LIM = 127;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            vnu_en;
  logic            in_ready;
  logic            first_iter;
  logic [W-1:0]    intrinsic_info;
  logic [DV*W-1:0] msg_from_check;
  logic [DV*W-1:0] msg_to_check;
  logic [W-1:0]    posterior;
  logic            hard_bit;
  logic            sat_flag;
  logic            vnu_over;
  logic            out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  vnu_pipe #(.W(W), .DV(DV), .SW(W + 4)) dut (
    .clk(clk), .rst_n(rst_n), .vnu_en(vnu_en), .in_ready(in_ready),
    .first_iter(first_iter), .intrinsic_info(intrinsic_info),
    .msg_from_check(msg_from_check), .msg_to_check(msg_to_check),
    .posterior(posterior), .hard_bit(hard_bit), .sat_flag(sat_flag),
    .vnu_over(vnu_over), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DV*W-1:0] msgs;
    logic [W-1:0]    post;
    logic            hb;
    logic            sat;
  } exp_t;

  // Directed vectors with hand-derived expectations.
  localparam int NV = 6;
  int v_fi [NV]     = '{1, 0, 0, 1, 0, 0};
  int v_in [NV]     = '{25, 10, 127, -128, -128, 0};
  int v_m  [NV][DV] = '{'{100, -50, 7}, '{5, -20, 3}, '{100, 100, 100},
                        '{0, 0, 0}, '{-128, -128, -128}, '{127, -127, 0}};
  int v_e  [NV][DV] = '{'{25, 25, 25}, '{-7, 18, -5}, '{127, 127, 127},
                        '{-127, -127, -127}, '{-127, -127, -127}, '{-127, 127, 0}};
  int v_p  [NV]     = '{25, -2, 127, -127, -127, 0};
  int v_h  [NV]     = '{0, 1, 0, 1, 1, 0};
  int v_s  [NV]     = '{0, 0, 1, 1, 1, 0};

  function automatic int clamp(input int v);
    if (v > LIM)  return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  function automatic exp_t model(input bit fi, input int intr, input int m[DV]);
    exp_t e;
    int tot, v;
    e = '0;
    if (fi) begin
      v = clamp(intr);
      for (int i = 0; i < DV; i++) e.msgs[i*W +: W] = W'(v);
      e.post = W'(v);
      e.hb   = (intr < 0);
      e.sat  = (v != intr);
    end else begin
      tot = intr;
      for (int i = 0; i < DV; i++) tot += m[i];
      for (int i = 0; i < DV; i++) begin
        v = clamp(tot - m[i]);
        e.msgs[i*W +: W] = W'(v);
        if (v != tot - m[i]) e.sat = 1'b1;
      end
      v = clamp(tot);
      e.post = W'(v);
      if (v != tot) e.sat = 1'b1;
      e.hb = (tot < 0);
    end
    return e;
  endfunction

  function automatic int rnd_llr();
    case ($urandom_range(0, 9))
      0:       return -128;
      1:       return 127;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  task automatic drive(input bit en, input bit fi, input int intr, input int m[DV]);
    vnu_en         = en;
    first_iter     = fi;
    intrinsic_info = W'(intr);
    for (int i = 0; i < DV; i++) msg_from_check[i*W +: W] = W'(m[i]);
  endtask

  function automatic exp_t observed();
    exp_t o;
    o = {msg_to_check, posterior, hard_bit, sat_flag};
    return o;
  endfunction

  task automatic test_reset();
    int z[DV] = '{0, 0, 0};
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 0, z);
    #1;
    n_chk++;
    if (vnu_over !== 1'b0) begin
      n_fail++; $display("FAIL reset_vnu_over: got %b expected 0", vnu_over);
    end
    n_chk++;
    if (observed() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    int   mm[DV];
    exp_t ex;
    for (int k = 0; k < NV; k++) begin
      for (int i = 0; i < DV; i++) begin
        mm[i] = v_m[k][i];
        ex.msgs[i*W +: W] = W'(v_e[k][i]);
      end
      ex.post = W'(v_p[k]);
      ex.hb   = 1'(v_h[k]);
      ex.sat  = 1'(v_s[k]);
      @(negedge clk);
      out_ready = 1'b1;
      drive(1'b1, 1'(v_fi[k]), v_in[k], mm);
      @(posedge clk); #1;
      n_chk++;
      if (vnu_over !== 1'b0) begin
        n_fail++; $display("FAIL dir%0d_latency1: vnu_over got %b expected 0", k, vnu_over);
      end
      @(negedge clk);
      vnu_en = 1'b0;
      @(posedge clk); #1;
      n_chk++;
      if (vnu_over !== 1'b1) begin
        n_fail++; $display("FAIL dir%0d_latency2: vnu_over got %b expected 1", k, vnu_over);
      end
      n_chk++;
      if (observed() !== ex) begin
        n_fail++; $display("FAIL dir%0d_data: got %h expected %h", k, observed(), ex);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_backpressure();
    exp_t q[$];
    exp_t held, ex;
    int   acc = 0, got = 0, cm[DV], ci = 0;
    bit   pend = 0, cf = 0, seen_block = 0, hold_chk = 0;
    for (int c = 0; c < 40 && (acc < 5 || q.size() > 0); c++) begin
      @(negedge clk);
      out_ready = !(c >= 1 && c <= 4);
      if (!pend && acc < 5) begin
        pend = 1; cf = ($urandom_range(0, 3) == 0); ci = rnd_llr();
        for (int i = 0; i < DV; i++) cm[i] = rnd_llr();
      end
      drive(pend, cf, ci, cm);
      #1;
      if (hold_chk) begin
        n_chk++;
        if (!vnu_over || observed() !== held) begin
          n_fail++; $display("FAIL bp_hold: got %b/%h expected 1/%h", vnu_over, observed(), held);
        end
      end
      if (vnu_over && out_ready) begin
        n_chk++;
        ex = (q.size() > 0) ? q.pop_front() : '1;
        if (observed() !== ex) begin
          n_fail++; $display("FAIL bp_order%0d: got %h expected %h", got, observed(), ex);
        end
        got++;
      end
      if (pend && !in_ready && !seen_block) begin
        seen_block = 1;
        n_chk++;
        if (acc != 2) begin
          n_fail++; $display("FAIL bp_block_point: accepted %0d expected 2", acc);
        end
      end
      hold_chk = vnu_over && !out_ready;
      held = observed();
      if (pend && in_ready) begin
        q.push_back(model(cf, ci, cm)); acc++; pend = 0;
      end
    end
    @(negedge clk);
    vnu_en = 1'b0;
    out_ready = 1'b1;
    n_chk++;
    if (got != 5 || !seen_block) begin
      n_fail++; $display("FAIL bp_count: got %0d outputs block=%b expected 5 block=1", got, seen_block);
    end
    repeat (3) begin
      @(posedge clk); #1;
      n_chk++;
      if (vnu_over !== 1'b0) begin
        n_fail++; $display("FAIL bp_no_dup: vnu_over got %b expected 0", vnu_over);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int   a[DV] = '{11, -22, 33};
    int   b[DV] = '{-5, 6, 7};
    int   c[DV] = '{40, 1, -3};
    exp_t ex;
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 60, a);
    @(negedge clk);
    drive(1'b1, 1'b1, -90, b);
    @(negedge clk);
    vnu_en = 1'b0;
    #1;
    n_chk++;
    if (vnu_over !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_full: vnu_over/in_ready got %b/%b expected 1/0", vnu_over, in_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (vnu_over !== 1'b0 || observed() !== '0) begin
      n_fail++; $display("FAIL mid_async_clear: got %b/%h expected 0/0", vnu_over, observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_chk++;
      if (vnu_over !== 1'b0) begin
        n_fail++; $display("FAIL mid_stale: vnu_over got %b expected 0", vnu_over);
      end
    end
    @(negedge clk);
    drive(1'b1, 1'b0, -70, c);
    ex = model(1'b0, -70, c);
    @(posedge clk); #1;
    n_chk++;
    if (vnu_over !== 1'b0) begin
      n_fail++; $display("FAIL mid_new_lat1: vnu_over got %b expected 0", vnu_over);
    end
    @(negedge clk);
    vnu_en = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (vnu_over !== 1'b1 || observed() !== ex) begin
      n_fail++; $display("FAIL mid_new_data: got %b/%h expected 1/%h", vnu_over, observed(), ex);
    end
    @(posedge clk);
  endtask

  task automatic test_stream(input string name, input int n, input int en_pct,
                             input int rdy_pct, input bit full_rate);
    exp_t q[$];
    exp_t held, ex;
    int   sent = 0, got = 0, cyc = 0, cm[DV], ci = 0;
    bit   pend = 0, cf = 0, hold_chk = 0;
    while ((sent < n || q.size() > 0) && cyc < 20 * n + 50) begin
      @(negedge clk);
      out_ready = ($urandom_range(1, 100) <= rdy_pct);
      if (!pend && sent < n && $urandom_range(1, 100) <= en_pct) begin
        pend = 1; cf = ($urandom_range(0, 3) == 0); ci = rnd_llr();
        for (int i = 0; i < DV; i++) cm[i] = rnd_llr();
      end
      drive(pend, cf, ci, cm);
      #1;
      if (hold_chk) begin
        n_chk++;
        if (!vnu_over || observed() !== held) begin
          n_fail++; $display("FAIL %s_hold: got %b/%h expected 1/%h", name, vnu_over, observed(), held);
        end
      end
      if (vnu_over && out_ready) begin
        n_chk++;
        ex = (q.size() > 0) ? q.pop_front() : '1;
        if (observed() !== ex) begin
          n_fail++; $display("FAIL %s_out%0d: got %h expected %h", name, got, observed(), ex);
        end
        got++;
      end
      hold_chk = vnu_over && !out_ready;
      held = observed();
      if (pend && in_ready) begin
        q.push_back(model(cf, ci, cm)); sent++; pend = 0;
      end
      cyc++;
    end
    @(negedge clk);
    vnu_en = 1'b0;
    out_ready = 1'b1;
    n_chk++;
    if (got != n) begin
      n_fail++; $display("FAIL %s_count: got %0d outputs expected %0d", name, got, n);
    end
    if (full_rate) begin
      n_chk++;
      if (cyc != n + 2) begin
        n_fail++; $display("FAIL %s_rate: took %0d cycles expected %0d", name, cyc, n + 2);
      end
    end
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_stream("back_to_back", 40, 100, 100, 1'b1);
    test_stream("random", 300, 70, 60, 1'b0);
    test_stream("heavy_bp", 150, 90, 25, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vnu_pipe.md
Name: vnu_pipe

Overview:
- Parametrised, pipelined variable-node update unit for the min-sum LDPC decoder.
- Handles first-iteration pass-through of intrinsic LLRs and all later iterations: extrinsic messages, posterior LLR and hard decision.
- Sits between the channel LLR buffer and the check-node units, with one instance per variable node or time-multiplexed.
- Accepts one variable node per cycle under valid/ready flow control.

Parameters:
- W, 8, message/LLR width; two's complement.
- DV, 3, variable-node degree, i.e. number of check messages in and out; legal range 2..16.
- SW, W+4, internal sum width; must be ≥ W+clog2(DV+1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- vnu_en  in  1  input valid; a transfer occurs when vnu_en && in_ready.
- in_ready  out  1  unit can accept an input this cycle.
- first_iter  in  1  when 1, pass intrinsic only and ignore check messages.
- intrinsic_info  in  W  channel LLR.
- msg_from_check  in  DV*W  check-to-variable messages; message i occupies bits [i*W +: W].
- msg_to_check  out  DV*W  variable-to-check messages, same packing.
- posterior  out  W  saturated a-posteriori LLR.
- hard_bit  out  1  hard decision: 1 when the unsaturated total is < 0.
- sat_flag  out  1  at least one output of this result was saturated.
- vnu_over  out  1  output valid.
- out_ready  in  1  downstream accepts; an output transfer occurs when vnu_over && out_ready.

Behaviour:
- Reset (rst_n low, asynchronous): stage valids cleared, vnu_over=0, msg_to_check=0, posterior=0, hard_bit=0, sat_flag=0. in_ready=1 once reset is released. Reset mid-operation discards all in-flight data; no stale vnu_over after release.
- Pipeline: two register stages, latency 2 cycles from accepted input to vnu_over, throughput 1 per cycle.
- Stage 1 registers:
  - first_iter
  - each check message
  - total = sext(intrinsic) + Σ sext(msg_i), computed at SW bits
- Stage 2 computes and registers the outputs.
- Normal mode (first_iter=0):
  - ext_i = total − msg_i at SW bits, then saturated.
  - posterior = sat(total).
  - hard_bit = total[SW-1].
- First-iteration mode (first_iter=1):
  - every ext_i = sat(intrinsic); check inputs ignored.
  - posterior = sat(intrinsic); hard_bit = intrinsic sign.
- Saturation is symmetric: the clamp range is ±(2^(W-1)−1), i.e. ±127 for W=8. −2^(W-1) is never emitted; intrinsic −128 maps to −127 and sets sat_flag.
- sat_flag = OR of the saturation events across all DV extrinsics and the posterior.
- Flow control:
  - s2_adv = !vnu_over || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational; no combinational path from vnu_en to in_ready).
  - Stage 2 loads only when s2_adv; stage 1 loads only when s1_adv.
- Output stability: while vnu_over && !out_ready, all outputs hold stable.
- Simultaneous accept and release:
  - With the pipeline full and out_ready=1, a new input is accepted the same cycle; no bubble.
  - With the pipeline full and out_ready=0, in_ready=0 and the input must be held by the source.
- Ordering is strictly FIFO; no reordering and no data loss.
- Inputs are sampled only on a transfer cycle; values outside transfer cycles are don't-care.

Test Plan (W=8, DV=3):
- Reset: pulse rst_n low asynchronously between clock edges → vnu_over=0, all data outputs 0 immediately; in_ready=1 after release.
- First iteration: first_iter=1, intrinsic=25, checks (100,−50,7), out_ready=1 → after 2 cycles msg_to_check=(25,25,25), posterior=25, hard_bit=0, sat_flag=0.
- Normal iteration: first_iter=0, intrinsic=10, checks (5,−20,3) → total −2; msg_to_check=(−7,18,−5), posterior=−2, hard_bit=1, sat_flag=0.
- Saturation:
  - intrinsic=127, checks (100,100,100) → extrinsics 327 clamp to (127,127,127), posterior=127, sat_flag=1.
  - first_iter=1, intrinsic=−128 → all outputs −127, sat_flag=1.
- Backpressure: 5 back-to-back inputs, out_ready=0 for cycles 2–5 → in_ready drops after 2 accepted; outputs held stable; after release all 5 emerge in order with exact values; no duplicates.
- Reset mid-flight: assert rst_n low with both stages valid and out_ready=0 → vnu_over drops immediately; after release, no output until a new input is accepted, then it appears 2 cycles later.
